gray_stream_decoder: RTL and testbench

GRAY_STREAM_DECODER -- requirements
Module: gray_stream_decoder

---
 rtl/gray_stream_decoder.sv | 79 +++++++
 tb/tb_gray_stream_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_stream_decoder.sv
// Streaming Gray-to-binary decoder with a one-word output register and a
// step checker that flags successive words differing in more than one bit.
//
// state | meaning
// SYNC  | no reference word; next accepted word is taken as-is
// TRACK | reference holds the last accepted Gray word
module gray_stream_decoder #(
   parameter int WIDTH     = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_gray,
   input  logic                 resync,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_bin,
   output logic                 out_step_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] ref_gray;
   logic [WIDTH-1:0] dec_bin;
   logic [WIDTH-1:0] diff;
   logic             accept;
   logic             multi_bit;
   logic             step_err;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      dec_bin = '0;
      dec_bin[WIDTH-1] = in_gray[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         dec_bin[i] = dec_bin[i+1] ^ in_gray[i];
      end
   end

   // Clearing the lowest set bit leaves something only if two or more bits differ.
   assign diff      = in_gray ^ ref_gray;
   assign multi_bit = |(diff & (diff - WIDTH'(1)));
   assign step_err  = (state == TRACK) && !resync && multi_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= SYNC;
         ref_gray     <= '0;
         out_valid    <= 1'b0;
         out_bin      <= '0;
         out_step_err <= 1'b0;
         err_count    <= '0;
      end else begin
         if (accept) begin
            out_valid    <= 1'b1;
            out_bin      <= dec_bin;
            out_step_err <= step_err;
            ref_gray     <= in_gray;
            state        <= TRACK;
            if (step_err && (err_count != {ERR_CNT_W{1'b1}})) begin
               err_count <= err_count + ERR_CNT_W'(1);
            end
         end else begin
            if (out_ready) begin
               out_valid <= 1'b0;
            end
            if (resync) begin
               state <= SYNC;
            end
         end
      end
   end

endmodule

// File: tb/tb_gray_stream_decoder.sv
// Self-checking bench for gray_stream_decoder: directed scenarios plus a
// randomized stream compared against a behavioural stream model.
module tb_gray_stream_decoder;
   localparam int W  = 4;
   localparam int EW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          resync = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  in_gray = '0;
   logic          in_ready;
   logic          out_valid;
   logic          out_step_err;
   logic [W-1:0]  out_bin;
   logic [EW-1:0] err_count;

   int tests = 0;
   int fails = 0;

   bit           m_have_ref;
   bit           m_ov;
   bit           m_serr;
   logic [W-1:0] m_ref;
   logic [W-1:0] m_bin;
   int           m_err;

   gray_stream_decoder #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_gray(in_gray), .resync(resync), .out_valid(out_valid),
      .out_ready(out_ready), .out_bin(out_bin), .out_step_err(out_step_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   // Binary bit i is the parity of all Gray bits at or above i.
   function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      for (int i = 0; i < W; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   task automatic model_reset();
      m_have_ref = 0; m_ov = 0; m_serr = 0; m_ref = '0; m_bin = '0; m_err = 0;
   endtask

   // One clock edge with the currently driven inputs; the model follows it.
   task automatic clock_once();
      bit acc;
      bit err;
      acc = in_valid && (!m_ov || out_ready);
      @(posedge clk);
      if (acc) begin
         err = m_have_ref && !resync && ($countones(in_gray ^ m_ref) > 1);
         m_ov = 1; m_bin = gray2bin(in_gray); m_serr = err;
         if (err && m_err < 3) m_err++;
         m_ref = in_gray; m_have_ref = 1;
      end else begin
         if (out_ready) m_ov = 0;
         if (resync) m_have_ref = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; in_valid = 0; resync = 0; out_ready = 0; in_gray = '0;
      #1 model_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
   endtask

   task automatic send(input logic [W-1:0] g);
      in_valid = 1; in_gray = g; out_ready = 1;
      clock_once();
      in_valid = 0;
   endtask

   task automatic test_reset();
      #3;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      tests++; if (out_bin !== 4'd0) begin fails++; $display("FAIL rst_bin got %h exp 0", out_bin); end
      tests++; if (err_count !== 2'd0 || out_step_err !== 1'b0) begin fails++; $display("FAIL rst_err got cnt %0d se %b exp 0 0", err_count, out_step_err); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] words [4];
      words = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
      out_ready = 1; in_valid = 1;
      for (int i = 0; i < 4; i++) begin
         in_gray = words[i];
         clock_once();
         tests++;
         if (out_valid !== 1'b1 || out_bin !== 4'(i) || out_step_err !== 1'b0 || err_count !== 2'd0) begin
            fails++;
            $display("FAIL b2b[%0d] got v%b bin %h se %b cnt %0d exp v1 bin %h se 0 cnt 0", i, out_valid, out_bin, out_step_err, err_count, 4'(i));
         end
      end
      in_valid = 0;
      clock_once();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got v%b exp 0", out_valid); end
   endtask

   task automatic test_backpressure();
      do_reset();
      send(4'b0110);
      out_ready = 0; in_valid = 1; in_gray = 4'b0111;
      #1;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_bin !== 4'b0100) begin
            fails++;
            $display("FAIL bp_hold[%0d] got rdy %b v %b bin %h exp 0 1 4", i, in_ready, out_valid, out_bin);
         end
         clock_once();
      end
      out_ready = 1; in_valid = 0;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_rdy got %b exp 1", in_ready); end
      clock_once();
      tests++; if (out_valid !== 1'b0 || out_bin !== 4'b0100) begin fails++; $display("FAIL bp_done got v %b bin %h exp 0 4", out_valid, out_bin); end
   endtask

   task automatic test_step_error();
      do_reset();
      send(4'b0010);
      send(4'b0111);
      tests++; if (out_bin !== 4'b0101 || out_step_err !== 1'b1 || err_count !== 2'd1) begin fails++; $display("FAIL step_err got bin %h se %b cnt %0d exp 5 1 1", out_bin, out_step_err, err_count); end
      send(4'b0000);
      tests++; if (out_step_err !== 1'b1 || err_count !== 2'd2) begin fails++; $display("FAIL step_err2 got se %b cnt %0d exp 1 2", out_step_err, err_count); end
      send(4'b1000);
      tests++; if (out_bin !== 4'b1111 || out_step_err !== 1'b0 || err_count !== 2'd2) begin fails++; $display("FAIL wrap_up got bin %h se %b cnt %0d exp f 0 2", out_bin, out_step_err, err_count); end
      send(4'b0000);
      tests++; if (out_bin !== 4'b0000 || out_step_err !== 1'b0 || err_count !== 2'd2) begin fails++; $display("FAIL wrap_down got bin %h se %b cnt %0d exp 0 0 2", out_bin, out_step_err, err_count); end
      send(4'b0000);
      tests++; if (out_step_err !== 1'b0) begin fails++; $display("FAIL repeat_word got se %b exp 0", out_step_err); end
   endtask

   task automatic test_saturation();
      int exp_cnt;
      do_reset();
      send(4'b0000);
      for (int i = 1; i <= 6; i++) begin
         send((i % 2 == 1) ? 4'b0011 : 4'b0000);
         exp_cnt = (i < 3) ? i : 3;
         tests++;
         if (out_step_err !== 1'b1 || err_count !== 2'(exp_cnt)) begin
            fails++;
            $display("FAIL sat[%0d] got se %b cnt %0d exp 1 %0d", i, out_step_err, err_count, exp_cnt);
         end
      end
   endtask

   task automatic test_resync();
      do_reset();
      send(4'b0000);
      send(4'b0101);
      out_ready = 0; resync = 1;
      clock_once();
      resync = 0;
      tests++; if (out_valid !== 1'b1 || out_bin !== 4'b0110 || err_count !== 2'd1) begin fails++; $display("FAIL resync_keep got v %b bin %h cnt %0d exp 1 6 1", out_valid, out_bin, err_count); end
      send(4'b1101);
      tests++; if (out_bin !== 4'b1001 || out_step_err !== 1'b0 || err_count !== 2'd1) begin fails++; $display("FAIL resync_first got bin %h se %b cnt %0d exp 9 0 1", out_bin, out_step_err, err_count); end
      send(4'b1100);
      tests++; if (out_step_err !== 1'b0) begin fails++; $display("FAIL resync_next got se %b exp 0", out_step_err); end
      resync = 1;
      send(4'b0011);
      resync = 0;
      tests++; if (out_step_err !== 1'b0 || err_count !== 2'd1) begin fails++; $display("FAIL resync_same got se %b cnt %0d exp 0 1", out_step_err, err_count); end
      send(4'b0000);
      tests++; if (out_step_err !== 1'b1 || err_count !== 2'd2) begin fails++; $display("FAIL resync_track got se %b cnt %0d exp 1 2", out_step_err, err_count); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      send(4'b0000);
      send(4'b0101);
      out_ready = 0;
      clock_once();
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || out_bin !== 4'd0 || out_step_err !== 1'b0 || err_count !== 2'd0) begin
         fails++;
         $display("FAIL mid_reset got v %b bin %h se %b cnt %0d exp 0 0 0 0", out_valid, out_bin, out_step_err, err_count);
      end
      model_reset();
      @(negedge clk) rst_n = 1'b1;
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_reset_rdy got %b exp 1", in_ready); end
      send(4'b1111);
      tests++; if (out_valid !== 1'b1 || out_bin !== 4'b1010 || out_step_err !== 1'b0) begin fails++; $display("FAIL mid_reset_first got v %b bin %h se %b exp 1 a 0", out_valid, out_bin, out_step_err); end
   endtask

   task automatic test_random();
      logic [W-1:0] last;
      int r;
      do_reset();
      last = '0;
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         resync    = ($urandom_range(0, 9) == 0);
         r = $urandom_range(0, 9);
         if (r < 6) last = last ^ (W'(1) << $urandom_range(0, W - 1));
         else if (r < 8) last = W'($urandom);
         in_gray = last;
         #1;
         tests++; if (in_ready !== (!m_ov || out_ready)) begin fails++; $display("FAIL rnd_rdy[%0d] got %b exp %b", n, in_ready, !m_ov || out_ready); end
         clock_once();
         tests++;
         if (out_valid !== m_ov || err_count !== 2'(m_err) ||
             (m_ov && (out_bin !== m_bin || out_step_err !== m_serr))) begin
            fails++;
            $display("FAIL rnd[%0d] got v %b bin %h se %b cnt %0d exp v %b bin %h se %b cnt %0d",
                     n, out_valid, out_bin, out_step_err, err_count, m_ov, m_bin, m_serr, m_err);
         end
      end
      in_valid = 0; resync = 0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_step_error();
      test_saturation();
      test_resync();
      test_reset_midstream();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end
endmodule
